bram_stream_fifo: RTL

- Valid/ready FIFO controller that drives an external simple-dual-port block RAM.
- The RAM has a synchronous write port (wr_en, addr_a, d_in) and a registered read port (addr_b in, d_out one cycle later).
- This block sits directly upstream of that RAM, generating all its control and address inputs, and directly downstream of it, consuming d_out into a 2-entry output skid buffer.
- It turns the raw RAM into a streaming message queue for the BP message pipeline, with full throughput in both directions.

---
 rtl/bram_stream_fifo_pkg.sv | 7 +
 rtl/bram_stream_skid.sv | 26 ++
 rtl/bram_stream_fifo.sv | 64 ++++++
 3 files changed

// File: rtl/bram_stream_fifo_pkg.sv
// bram_stream_fifo_pkg: shared constants for the BRAM-backed stream FIFO.
package bram_stream_fifo_pkg;
  localparam int SKID_DEPTH = 2;
  function automatic int count_width(input int addr_width);
    return addr_width + 2;
  endfunction
endpackage

// File: rtl/bram_stream_skid.sv
// bram_stream_skid: 2-entry capture/pop buffer, head registered at entry 0.
module bram_stream_skid
  import bram_stream_fifo_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       occ
);
  logic [WIDTH-1:0] e1;
  logic [1:0] tail;
  assign tail = occ - {1'b0, rd};
  // Entries are not reset: the head must hold its last value while empty.
  always_ff @(posedge clk) begin
    if (rst) occ <= '0;
    else occ <= occ + {1'b0, wr} - {1'b0, rd};
    if (!rst && rd && occ == 2'(SKID_DEPTH)) data <= e1;
    else if (!rst && wr && tail == 2'd0) data <= wr_data;
    if (!rst && wr && tail == 2'd1) e1 <= wr_data;
  end
endmodule

// File: rtl/bram_stream_fifo.sv
// bram_stream_fifo: valid/ready FIFO controller driving an external simple-dual-port BRAM.
module bram_stream_fifo
  import bram_stream_fifo_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [WIDTH-1:0]                    out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                ram_wr_en,
  output logic [ADDR_WIDTH-1:0]               ram_wr_addr,
  output logic [WIDTH-1:0]                    ram_wr_data,
  output logic [ADDR_WIDTH-1:0]               ram_rd_addr,
  input  logic [WIDTH-1:0]                    ram_rd_data,
  output logic [count_width(ADDR_WIDTH)-1:0]  count
);
  localparam int CW = count_width(ADDR_WIDTH);
  localparam int NW = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] ram_cnt;
  logic rd_inflight, push, pop, issue;
  logic [1:0] skid_occ;
  assign in_ready    = ram_cnt != NW'(DEPTH);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = in_data;
  assign ram_rd_addr = rd_ptr;
  // Slots the skid will need next cycle must stay below its depth.
  assign issue = (ram_cnt != '0) &&
                 (3'(skid_occ) + 3'(rd_inflight) < 3'(SKID_DEPTH) + 3'(pop));
  assign out_valid = skid_occ != 2'd0;
  assign count = CW'(ram_cnt) + CW'(rd_inflight) + CW'(skid_occ);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + ADDR_WIDTH'(push);
      rd_ptr      <= rd_ptr + ADDR_WIDTH'(issue);
      ram_cnt     <= ram_cnt + NW'(push) - NW'(issue);
      rd_inflight <= issue;
    end
  end
  bram_stream_skid #(.WIDTH(WIDTH)) skid (
    .clk(clk),
    .rst(rst),
    .wr(rd_inflight),
    .wr_data(ram_rd_data),
    .rd(pop),
    .data(out_data),
    .occ(skid_occ)
  );
endmodule
